// File: rtl/rs232_in_oversampled.sv
// Oversampling RS232 receiver: 16x sampling with a mid-bit majority vote,
// framing check and a small receive FIFO with a valid/ready handshake.
//
// state     | meaning
// IDLE      | waiting for a falling edge on the synchronised line
// START     | confirming the start bit at mid-bit
// DATA      | sampling DATA_WIDTH data bits, LSB first
// STOP      | checking the stop bit and handing the word to the FIFO
// WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module rs232_in_oversampled #(
    parameter int DATA_WIDTH = 9,
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_data_in,
    input  logic                  receive_data_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  receiving_data,
    output logic                  framing_error,
    output logic                  overrun_error
);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t state, state_nxt;

    logic                  sync1, rxs, prev_rxs;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [3:0]            s;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  v7, v8, vote, start_det, mid, last_bit;
    logic                  push_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= serial_data_in;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick      = (tick_cnt == TW'(BAUD_DIV - 1));
    assign vote      = (v7 & v8) | (v7 & rxs) | (v8 & rxs);
    assign start_det = receive_data_en && !rxs && prev_rxs;
    assign mid       = tick && (s == 4'd9);
    assign last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tick && start_det) state_nxt = START;
            START: begin
                if (mid && vote)                     state_nxt = IDLE;
                else if (tick && s == 4'd15)         state_nxt = DATA;
            end
            DATA:      if (tick && s == 4'd15 && last_bit) state_nxt = STOP;
            STOP:      if (mid) state_nxt = vote ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (tick && rxs) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        receiving_data = (state != IDLE);
        push_req       = (state == STOP) && mid && vote;
        framing_error  = (state == STOP) && mid && !vote;
    end

    // prev_rxs clears on reset so a line already low out of reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_rxs  <= 1'b0;
            s         <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            v7        <= 1'b0;
            v8        <= 1'b0;
        end else if (tick) begin
            prev_rxs <= rxs;
            case (state)
                IDLE:      s <= start_det ? 4'd1 : 4'd0;
                WAIT_HIGH: s <= '0;
                default:   s <= s + 4'd1;
            endcase
            if (state != IDLE && s == 4'd7) v7 <= rxs;
            if (state != IDLE && s == 4'd8) v8 <= rxs;
            if (state == START && s == 4'd15) bit_cnt <= '0;
            if (state == DATA && s == 4'd9) shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            if (state == DATA && s == 4'd15 && !last_bit) bit_cnt <= bit_cnt + BW'(1);
        end
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  pop, full, push_ok;

    assign rx_valid      = (count != '0);
    assign pop           = rx_valid && rx_ready;
    assign full          = (count == CW'(FIFO_DEPTH));
    assign push_ok       = push_req && (!full || pop);
    assign overrun_error = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift_reg;
    end

    // rx_data tracks the head; a push into an emptying FIFO bypasses storage
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_ok && (count == '0 || (count == CW'(1) && pop)))
                rx_data <= shift_reg;
            else if (pop && count > CW'(1))
                rx_data <= mem[rd_ptr + AW'(1)];
        end
    end
endmodule

// File: tb/tb_rs232_in_oversampled.sv
// Scoreboard bench for rs232_in_oversampled: expected words are queued as
// frames are driven and checked as the receiver hands them over.
module tb_rs232_in_oversampled;
    localparam int DW  = 9;
    localparam int BD  = 4;
    localparam int FD  = 4;
    localparam int BIT = 16 * BD;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_data_in = 1'b1;
    logic          receive_data_en = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid, receiving_data, framing_error, overrun_error;

    rs232_in_oversampled #(.DATA_WIDTH(DW), .BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
        .clk             (clk),
        .reset           (reset),
        .serial_data_in  (serial_data_in),
        .receive_data_en (receive_data_en),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .receiving_data  (receiving_data),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    int            fe_cnt = 0, ov_cnt = 0, valid_cycles = 0;
    logic          fe_prev = 1'b0, ov_prev = 1'b0, busy_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (receiving_data) busy_seen = 1'b1;
        if (framing_error) begin
            fe_cnt++;
            chk("fe_single_cycle", 32'(fe_prev), 32'd0);
        end
        if (overrun_error) begin
            ov_cnt++;
            chk("ov_single_cycle", 32'(ov_prev), 32'd0);
        end
        fe_prev = framing_error;
        ov_prev = overrun_error;
        if (rx_valid && rx_ready && !reset) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int nbits);
        serial_data_in = b;
        wait_clks(BIT * nbits);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit good_stop);
        drive_bit(1'b0, 1);
        for (int i = 0; i < DW; i++) drive_bit(d[i], 1);
        if (good_stop) drive_bit(1'b1, 1);
        else begin
            drive_bit(1'b0, 3);
            serial_data_in = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(receiving_data), 32'd0);
        chk("rst_fe", 32'(framing_error), 32'd0);
        chk("rst_ov", 32'(overrun_error), 32'd0);
        wait_clks(BIT);
        receive_data_en = 1'b1;
        rx_ready = 1'b1;

        // good frame, consumed immediately
        valid_cycles = 0; fe_cnt = 0; ov_cnt = 0;
        exp_q.push_back(9'h1A5);
        fork
            send_frame(9'h1A5, 1'b1);
            begin
                k = 0;
                while (!receiving_data && k < 2 * BIT) begin @(negedge clk); k++; end
                while (receiving_data && k < 20 * BIT) begin @(negedge clk); k++; end
                chk("t1_busy_drop", 32'(receiving_data), 32'd0);
                chk("t1_valid_at_push", 32'(rx_valid), 32'd1);
                chk("t1_data_at_push", 32'(rx_data), 32'h1A5);
            end
        join
        wait_clks(BIT);
        chk("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("t1_fe", 32'(fe_cnt), 32'd0);
        chk("t1_ov", 32'(ov_cnt), 32'd0);
        chk("t1_busy", 32'(receiving_data), 32'd0);

        // short low glitch must abort in START
        busy_seen = 1'b0;
        serial_data_in = 1'b0;
        wait_clks(20);
        serial_data_in = 1'b1;
        wait_clks(3 * BIT);
        chk("t2_start_seen", 32'(busy_seen), 32'd1);
        chk("t2_busy", 32'(receiving_data), 32'd0);
        chk("t2_valid", 32'(rx_valid), 32'd0);
        chk("t2_valid_cycles", 32'(valid_cycles), 32'd1);
        chk("t2_fe", 32'(fe_cnt), 32'd0);

        // bad stop bit held low, then a good frame
        send_frame(9'h0F0, 1'b0);
        wait_clks(2 * BIT);
        chk("t3_fe", 32'(fe_cnt), 32'd1);
        chk("t3_valid", 32'(rx_valid), 32'd0);
        chk("t3_busy", 32'(receiving_data), 32'd0);
        exp_q.push_back(9'h055);
        send_frame(9'h055, 1'b1);
        wait_clks(BIT);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // fill FIFO with no consumer, fifth word overruns
        rx_ready = 1'b0;
        ov_cnt = 0;
        for (int d = 1; d <= 4; d++) exp_q.push_back(DW'(d));
        for (int d = 1; d <= 5; d++) send_frame(DW'(d), 1'b1);
        wait_clks(BIT);
        chk("t4_ov", 32'(ov_cnt), 32'd1);
        chk("t4_valid", 32'(rx_valid), 32'd1);
        chk("t4_head", 32'(rx_data), 32'h001);
        rx_ready = 1'b1;
        wait_clks(10);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_empty", 32'(rx_valid), 32'd0);

        // reset mid-data abandons the frame
        fe_cnt = 0;
        fork
            send_frame(9'h1FF, 1'b1);
            begin
                wait_clks(4 * BIT);
                chk("t5_busy_before", 32'(receiving_data), 32'd1);
                reset = 1'b1;
                wait_clks(1);
                reset = 1'b0;
                @(negedge clk);
                chk("t5_rx_data", 32'(rx_data), 32'd0);
                chk("t5_valid", 32'(rx_valid), 32'd0);
                chk("t5_busy", 32'(receiving_data), 32'd0);
            end
        join
        wait_clks(BIT);
        chk("t5_no_push", 32'(rx_valid), 32'd0);
        chk("t5_fe", 32'(fe_cnt), 32'd0);
        exp_q.push_back(9'h123);
        send_frame(9'h123, 1'b1);
        wait_clks(BIT);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // enable gating: disabled frame, then enable late in a frame
        receive_data_en = 1'b0;
        busy_seen = 1'b0;
        send_frame(9'h0AA, 1'b1);
        wait_clks(BIT);
        chk("t6_disabled_busy", 32'(busy_seen), 32'd0);
        chk("t6_disabled_valid", 32'(rx_valid), 32'd0);
        fork
            send_frame(9'h0AA, 1'b1);
            begin
                wait_clks(9 * BIT + BIT / 2);
                receive_data_en = 1'b1;
            end
        join
        wait_clks(BIT);
        chk("t6_residual_busy", 32'(busy_seen), 32'd0);
        chk("t6_residual_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(9'h155);
        send_frame(9'h155, 1'b1);
        wait_clks(BIT);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs232_in_oversampled.md
Name: rs232_in_oversampled

Overview:
- Robust RS232 receiver for the serial link driven by RS232_Out. Complements the existing single-sample receiver.
- Synchronises the asynchronous line and samples it 16x per bit, with a majority vote at mid-bit.
- Checks framing and buffers received words in a small FIFO with a valid/ready handshake.
- Sits between the external serial pin and the packet logic that consumes received words.

Parameters:
- DATA_WIDTH, 9, data bits per frame, sent LSB first.
- BAUD_DIV, 27, clk cycles per oversample tick; one bit = 16*BAUD_DIV cycles.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, 2 or more.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- serial_data_in  input  1  asynchronous serial line; idles high
- receive_data_en  input  1  enables detection of new frames
- rx_data  output  DATA_WIDTH  word at FIFO head
- rx_valid  output  1  FIFO not empty
- rx_ready  input  1  consumer accepts rx_data this cycle
- receiving_data  output  1  high whenever the FSM is not in IDLE
- framing_error  output  1  one-cycle pulse on a bad stop bit
- overrun_error  output  1  one-cycle pulse when a good word is dropped because the FIFO is full

Behaviour:
- Reset (clk edge with reset=1):
  - FSM goes to IDLE; tick counter, sample counter, bit counter and FIFO pointers clear.
  - All outputs are 0, including rx_data.
  - Synchroniser flops preset to 1.
  - A reset mid-frame abandons that frame silently.
- Synchroniser: two flops on serial_data_in; all logic uses the second flop (rxs). Pin-to-rxs latency is 2 cycles.
- Tick: a free-running counter 0..BAUD_DIV-1 pulses tick when it equals BAUD_DIV-1.
- All FSM actions occur only on tick cycles. Sample counter s counts 0..15 within a bit.
- Majority: vote = majority of rxs captured at s=7, 8 and 9. The decision is made at s=9.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1).
- FSM states:
  - IDLE: on a tick with receive_data_en=1, rxs=0 and prev_rxs=1 (falling edge, prev_rxs sampled each tick) -> START, s=1. Edges while receive_data_en=0 are ignored. A line already low when leaving reset is not a start.
  - START: at s=9, if vote=1 (glitch) -> IDLE; otherwise continue. At s=15 -> DATA, bit counter=0, s=0.
  - DATA: at s=9, shift vote into the MSB of the shift register (right shift). At s=15, if bit counter = DATA_WIDTH-1 -> STOP; otherwise increment the bit counter. s wraps 15->0.
  - STOP: at s=9:
    - vote=1: push the word to the FIFO, then -> IDLE.
    - vote=0: pulse framing_error, discard the word, then -> WAIT_HIGH.
  - WAIT_HIGH: on a tick with rxs=1 -> IDLE. This covers break conditions; no further errors are flagged.
- Enable timing: deasserting receive_data_en mid-frame does not abort the frame; it only gates new starts.
- FIFO:
  - rx_valid = !empty; rx_data = head entry, registered, valid whenever rx_valid=1.
  - Pop on rx_valid && rx_ready.
  - A push at the mid-stop tick gives rx_valid=1 on the following cycle (1-cycle latency after the push edge).
  - Full and no pop: the new word is dropped, overrun_error pulses, and stored words are unchanged.
  - Full and pop in the same cycle: the push is accepted and no overrun is flagged.
  - Empty: rx_ready is ignored. Pointers wrap modulo FIFO_DEPTH.
- framing_error and overrun_error are never held high for more than one cycle.

Test Plan:
- BAUD_DIV=4, DATA_WIDTH=9 (bit = 64 clk). Send 9'h1A5 with a good stop bit, rx_ready=1 -> rx_valid=1 for exactly 1 cycle, rx_data=9'h1A5, no error pulses, receiving_data low after the stop mid-bit.
- Low glitch on the idle line for 20 clk -> START aborts at s=9, no push, no errors, FSM returns to IDLE.
- Frame 9'h0F0 with the stop bit held low for 3 bit times -> one framing_error pulse, FIFO empty. The next valid frame 9'h055 after the line goes high is received correctly.
- rx_ready=0, send 9'h001..9'h005 back to back -> 4 words stored, overrun_error pulses once at the 5th stop bit. Draining then yields 9'h001, 9'h002, 9'h003, 9'h004 in order.
- Assert reset for 1 cycle mid-data of 9'h1FF -> no push, outputs 0. The next frame 9'h123 is received intact.
- receive_data_en=0, send 9'h0AA -> nothing received. Raise enable mid-frame -> the residual frame is not captured; the following 9'h155 is captured.
